// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters (master) and rr_arbiter4 (slave).
interface rr_arbiter4_if;
  logic       E;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (output E, req, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (input E, req, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered grants and a one-cycle bubble
// between owners. Define ARB_TIMEOUT_EN to force-release grants held MAX_HOLD cycles.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter4_if.slave  bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter4: MAX_HOLD must be within 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] gnt_q, gnt_d;
  logic       hit;
  logic [1:0] win;
  logic [1:0] cand;
  logic       rel;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // Rotating priority scan starting at ptr_q.
  always_comb begin
    hit  = 1'b0;
    win  = ptr_q;
    cand = ptr_q;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!hit && bus.req[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = '0;
    rel     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.E && hit) begin
          state_d = GRANT;
          idx_d   = win;
          gnt_d   = 4'b0001 << win;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        rel = !(bus.E && bus.req[idx_q]);
`ifdef ARB_TIMEOUT_EN
        // cnt_q counts completed grant cycles; the last allowed one ends at MAX_HOLD-1.
        if (!rel) begin
          if (cnt_q == 8'(MAX_HOLD - 1)) begin
            rel       = 1'b1;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
`endif
        if (rel) begin
          state_d = IDLE;
          ptr_d   = idx_q + 2'd1;
        end else begin
          gnt_d = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = (state_q == GRANT);
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural round-robin model.
module tb_rr_arbiter4;

  localparam int unsigned HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  rr_arbiter4_if bus ();

  rr_arbiter4 #(.MAX_HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: owner index (-1 when idle), priority pointer, last index,
  // number of cycles the current grant has been visible, timeout pulse.
  int m_owner, m_ptr, m_idx, m_cnt;
  bit m_to;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_idx = 0; m_cnt = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic e);
    bit found;
    bit drop;
    m_to = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      if (e) begin
        for (int j = 0; j < 4; j++) begin
          if (!found && r[(m_ptr + j) % 4]) begin
            found   = 1'b1;
            m_owner = (m_ptr + j) % 4;
          end
        end
      end
      if (found) begin
        m_idx = m_owner;
        m_cnt = 1;
      end
    end else begin
      drop = !e || !r[m_owner];
      if (!drop && TO_EN && m_cnt == int'(HOLD)) begin
        drop = 1'b1;
        m_to = 1'b1;
      end
      if (drop) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    return {g, 2'(m_idx), (m_owner >= 0), m_to};
  endfunction

  function automatic logic [7:0] dut_out();
    return {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got {gnt,idx,valid,timeout}=%b required %b", name, got, exp);
    end
  endtask

  // Drive inputs, let one rising edge sample them, then compare against the model.
  task automatic step(input string name, input logic [3:0] r, input logic e);
    bus.req = r;
    bus.E   = e;
    @(posedge clk);
    model_step(r, e);
    #1;
    check(name, dut_out(), model_out());
  endtask

  typedef struct {
    logic [3:0] req;
    logic       e;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  vec_t vecs[24];
  int   to_pulses;
  logic [3:0] r;
  logic       e;

  initial begin
    // rotation
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
    vecs[1]  = '{4'b1110, 1'b1, 4'b0000, 2'd0, 1'b0};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    vecs[3]  = '{4'b1101, 1'b1, 4'b0000, 2'd1, 1'b0};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
    vecs[5]  = '{4'b1011, 1'b1, 4'b0000, 2'd2, 1'b0};
    vecs[6]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
    vecs[7]  = '{4'b0111, 1'b1, 4'b0000, 2'd3, 1'b0};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
    vecs[9]  = '{4'b1110, 1'b1, 4'b0000, 2'd0, 1'b0};
    // pointer wrap and skip
    vecs[10] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
    vecs[11] = '{4'b0011, 1'b1, 4'b0000, 2'd2, 1'b0};
    vecs[12] = '{4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1};
    vecs[13] = '{4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0};
    // enable gating
    vecs[14] = '{4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[15] = '{4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[16] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
    vecs[17] = '{4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0};
    vecs[18] = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
    // simultaneous owner drop and E fall
    vecs[19] = '{4'b0111, 1'b1, 4'b0000, 2'd3, 1'b0};
    vecs[20] = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1};
    vecs[21] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};
    vecs[22] = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
    vecs[23] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};

    rst_n   = 1'b0;
    bus.req = 4'b0000;
    bus.E   = 1'b0;
    model_reset();
    #12;
    check("reset_state", dut_out(), 8'b0000_00_0_0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step($sformatf("vec%0d_model", i), vecs[i].req, vecs[i].e);
      check($sformatf("vec%0d_table", i), dut_out(),
            {vecs[i].gnt, vecs[i].idx, vecs[i].valid, 1'b0});
    end

    // Long hold with req=0011; ptr is at 3, so index 0 wins first.
    to_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step($sformatf("hold%0d", i), 4'b0011, 1'b1);
      if (bus.timeout === 1'b1) to_pulses++;
    end
    n_checks++;
`ifdef ARB_TIMEOUT_EN
    if (to_pulses != 4) begin
      n_errors++;
      $display("FAIL hold_timeouts: got %0d pulses required 4", to_pulses);
    end
`else
    if (to_pulses != 0 || bus.gnt !== 4'b0001) begin
      n_errors++;
      $display("FAIL hold_forever: got pulses=%0d gnt=%b required 0 and 0001", to_pulses, bus.gnt);
    end
`endif
    step("hold_drop", 4'b0000, 1'b1);

    // Asynchronous reset in the middle of a grant, between clock edges.
    step("pre_reset_grant", 4'b0100, 1'b1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", dut_out(), 8'b0000_00_0_0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_grant", 4'b1111, 1'b1);
    check("post_reset_gnt0", dut_out(), 8'b0001_00_1_0);
    step("post_reset_drop", 4'b0000, 1'b1);

    // Randomized traffic; the owner usually keeps its request up.
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom);
      e = ($urandom_range(0, 9) != 0);
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      step($sformatf("rand%0d", i), r, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
